// File: rtl/aoi_serial_ctrl.sv
// aoi_serial_ctrl: bit-serial evaluator of x = ~((a&b)|c) over WIDTH-bit operands.
// Uses a single 1-bit AOI slice, processes one bit per clock, LSB first, and
// publishes the assembled result atomically on completion.
// Optional feature: define AOI_PARITY_EN to add a registered parity output (^x_out).
module aoi_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x_out
`ifdef AOI_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] x_out_q, x_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             slice_c;
`ifdef AOI_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // The shared 1-bit AOI slice, fed from the operand LSBs.
    always_comb begin
        slice_c = ~((a_q[0] & b_q[0]) | c_q[0]);
    end

    // Next-state, datapath sequencing and registered-output targets.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        x_out_d = x_out_q;
`ifdef AOI_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    c_d     = c_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d = {slice_c, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_q >> 1;
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the full result in the same edge.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    x_out_d = res_d;
`ifdef AOI_PARITY_EN
                    parity_d = ^res_d;
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            x_out_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef AOI_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            x_out_q <= x_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef AOI_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign x_out = x_out_q;
`ifdef AOI_PARITY_EN
    assign parity = parity_q;
`endif

endmodule

// File: doc/aoi_serial_ctrl.md
# aoi_serial_ctrl

Bit-serial sequencer that evaluates the AOI function x = ~((a&b)|c) across WIDTH-bit operand vectors by time-sharing a single 1-bit AOI slice, one bit per clock, LSB first. It sits between a register-level requester (start/done handshake) and the 1-bit AOI datapath, and trades latency for area. The block latches operands, steps a bit index, assembles the result in a shift register, and publishes it atomically on completion.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous, active-high; sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on the accepted start edge.
- b_in  input  WIDTH  operand B; captured on the accepted start edge.
- c_in  input  WIDTH  operand C; captured on the accepted start edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse in DONE; x_out is valid from this cycle on.
- x_out  output  WIDTH  last completed result; held until the next completion.
- parity  output  1  XOR-reduction of x_out; present only with AOI_PARITY_EN.

## Operation
- State machine: IDLE, RUN, DONE. Encoding is free; no other reachable states.
- IDLE: busy=0, done=0. If start=1 on an edge, capture a_in/b_in/c_in into operand shift registers, clear bit counter to 0, go to RUN. If start=0, stay.
- RUN: each edge, feed operand LSBs (a[0], b[0], c[0]) to the AOI slice, shift its output into the MSB of the result shift register, shift operands right by one, and increment the counter. When the counter equals WIDTH-1 on an edge, that edge writes the final bit, copies the full result into x_out, and moves to DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Bit counter width: $clog2(WIDTH); no wrap is reachable because RUN exits at WIDTH-1.
- Result bit i equals ~((a_in[i]&b_in[i])|c_in[i]) for the captured operands.
- start in RUN or DONE is ignored (not queued). Operand input changes after capture have no effect.
- x_out never shows partial results; it changes only on the RUN->DONE edge or on reset.

## Timing
- Reset (rst=1 on any edge, in any state): state=IDLE, busy=0, done=0, x_out=0, parity=0, counter=0, shift registers=0. Reset mid-RUN aborts the operation; no done pulse follows.
- rst and start both high on the same edge: rst wins.
- Latency: start accepted at edge T0 -> busy=1 from T0. x_out updated and done=1 from edge T0+WIDTH. busy/done drop at edge T0+WIDTH+1.
- Minimum start-to-start spacing is WIDTH+2 cycles. A start held high continuously is accepted again in the first IDLE cycle (edge T0+WIDTH+2).
- All outputs are registered; no combinational path runs from inputs to outputs.

## Configuration
- AOI_PARITY_EN defined: the parity port exists and is registered. It is updated on the same edge as x_out with ^result and reset to 0.
- AOI_PARITY_EN undefined: the parity port and its register are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, reset, then start with a=F0, b=CC, c=0A -> done pulse 8 cycles after accept, x_out=35, parity=0, busy high for exactly 9 cycles.
- a=01, b=01, c=00 -> x_out=FE, parity=1. Then a=00, b=00, c=00 -> x_out=FF, parity=0.
- Start held high for 30 cycles with a=FF, b=FF, c=00 -> results at accept spacing of 10 cycles, each x_out=00, one done pulse per operation.
- Toggle start and change a/b/c during RUN -> ignored. Result matches the captured operands; x_out keeps its old value until done.
- Assert rst at the 4th RUN cycle -> next cycle busy=0, done=0, x_out=00, no done pulse. A fresh start then completes normally.
- rst and start high on the same edge -> stays IDLE, busy=0.
